// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: frame FSM states and scan-code prefix bytes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } frame_state_e;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] PS2_PAUSE = 8'hE1;

    // Pause/Break is E1 followed by seven more bytes that carry no key event.
    localparam logic [2:0] PS2_PAUSE_SKIP = 3'd7;

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 bit receiver: sync + glitch filter on ps2_clk, 11-bit frame FSM, inactivity timeout.
// Latency: byte_valid / frame_err pulse one cycle after the STOP strobe; timeout pulse one cycle after expiry.
// Backpressure: none, the keyboard cannot be stalled; optional odd-parity drop with PS2_PARITY_CHECK_EN.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] byte_dat,
    output logic       byte_valid,
    output logic       frame_err,
    output logic       frame_tmo
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;

    logic          filt_q, filt_d, filt_prev_q;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          strobe;
    logic          timeout;

    frame_state_e  state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    byte_q, byte_d;
    logic          byte_vld_q, byte_vld_d;
    logic          ferr_q, ferr_d;
    logic          tmo_evt_q, tmo_evt_d;

    // Two-flop synchronizers; idle PS/2 lines are high, so reset to 1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= ps2_clk;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_dat;
            dat_s2_q <= dat_s1_q;
        end
    end

    // Filter: accept a new ps2_clk level only after FILTER_LEN consecutive differing samples.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (clk_s2_q != filt_q) begin
            if (fcnt_q == FW'(FILTER_LEN - 1)) begin
                filt_d = clk_s2_q;
            end else begin
                fcnt_d = fcnt_q + FW'(1);
            end
        end
    end

    // Filter state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
            fcnt_q      <= '0;
        end else begin
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            fcnt_q      <= fcnt_d;
        end
    end

    assign strobe  = filt_prev_q & ~filt_q;
    // Timeout is evaluated independently of strobe so that it wins a same-cycle tie.
    assign timeout = (state_q != IDLE) && (tmo_q == TW'(TIMEOUT_CYC - 1));

    // Frame FSM next state, shift register, timeout counter and result pulses.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        tmo_d      = tmo_q;
        byte_d     = byte_q;
        byte_vld_d = 1'b0;
        ferr_d     = 1'b0;
        tmo_evt_d  = 1'b0;
        if (timeout) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            shift_d   = '0;
            tmo_d     = '0;
            ferr_d    = 1'b1;
            tmo_evt_d = 1'b1;
        end else if (strobe) begin
            tmo_d = '0;
            case (state_q)
                IDLE: begin
                    if (!dat_s2_q) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    shift_d = {dat_s2_q, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d = '0;
                        state_d   = PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                PARITY: begin
                    par_d   = dat_s2_q;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (!dat_s2_q) begin
                        ferr_d = 1'b1;
`ifdef PS2_PARITY_CHECK_EN
                    end else if (!(^{shift_q, par_q})) begin
                        // Even count of ones across data + parity: odd parity violated.
                        ferr_d = 1'b1;
`endif
                    end else begin
                        byte_d     = shift_q;
                        byte_vld_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE) begin
            tmo_d = tmo_q + TW'(1);
        end else begin
            tmo_d = '0;
        end
    end

    // Frame FSM registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            tmo_q      <= '0;
            byte_q     <= '0;
            byte_vld_q <= 1'b0;
            ferr_q     <= 1'b0;
            tmo_evt_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            tmo_q      <= tmo_d;
            byte_q     <= byte_d;
            byte_vld_q <= byte_vld_d;
            ferr_q     <= ferr_d;
            tmo_evt_q  <= tmo_evt_d;
        end
    end

    assign byte_dat   = byte_q;
    assign byte_valid = byte_vld_q;
    assign frame_err  = ferr_q;
    assign frame_tmo  = tmo_evt_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard decoder: frame receiver plus E0/F0/E1 prefix handling into key events.
// Latency: key_valid one cycle after a byte leaves the receiver; frame_err straight from the receiver.
// Backpressure: none; events are single-cycle pulses. Build option PS2_PARITY_CHECK_EN drops bad-parity frames.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] keycode,
    output logic       key_make,
    output logic       key_ext,
    output logic       key_valid,
    output logic       frame_err
);

    logic [7:0] rx_byte;
    logic       rx_vld;
    logic       rx_ferr;
    logic       rx_tmo;

    logic       ext_q, ext_d;
    logic       brk_q, brk_d;
    logic [2:0] skip_q, skip_d;
    logic [7:0] keycode_q, keycode_d;
    logic       make_q, make_d;
    logic       kext_q, kext_d;
    logic       kvld_q, kvld_d;

    ps2_rx_frame #(
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_dat    (ps2_dat),
        .byte_dat   (rx_byte),
        .byte_valid (rx_vld),
        .frame_err  (rx_ferr),
        .frame_tmo  (rx_tmo)
    );

    // Prefix decoder: flags accumulate in any order and are consumed by the next plain byte.
    always_comb begin
        ext_d     = ext_q;
        brk_d     = brk_q;
        skip_d    = skip_q;
        keycode_d = keycode_q;
        make_d    = make_q;
        kext_d    = kext_q;
        kvld_d    = 1'b0;
        if (rx_tmo) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (rx_vld) begin
            if (skip_q != 3'd0) begin
                skip_d = skip_q - 3'd1;
            end else if (rx_byte == PS2_EXT) begin
                ext_d = 1'b1;
            end else if (rx_byte == PS2_BRK) begin
                brk_d = 1'b1;
            end else if (rx_byte == PS2_PAUSE) begin
                skip_d = PS2_PAUSE_SKIP;
            end else begin
                keycode_d = rx_byte;
                make_d    = ~brk_q;
                kext_d    = ext_q;
                kvld_d    = 1'b1;
                ext_d     = 1'b0;
                brk_d     = 1'b0;
            end
        end
    end

    // Decoder and event output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ext_q     <= 1'b0;
            brk_q     <= 1'b0;
            skip_q    <= '0;
            keycode_q <= '0;
            make_q    <= 1'b0;
            kext_q    <= 1'b0;
            kvld_q    <= 1'b0;
        end else begin
            ext_q     <= ext_d;
            brk_q     <= brk_d;
            skip_q    <= skip_d;
            keycode_q <= keycode_d;
            make_q    <= make_d;
            kext_q    <= kext_d;
            kvld_q    <= kvld_d;
        end
    end

    assign keycode   = keycode_q;
    assign key_make  = make_q;
    assign key_ext   = kext_q;
    assign key_valid = kvld_q;
    assign frame_err = rx_ferr;

endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 The block SHALL take parameter FILTER_LEN, default 4, the number of consecutive equal clk samples needed to accept a ps2_clk level change.
REQ-002 The block SHALL take parameter TIMEOUT_CYC, default 50000, the clk cycles without a ps2_clk falling edge that abort a partial frame.
REQ-003 The block SHALL have a single clock and an asynchronous active-low reset, with ports as follows.
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low
- ps2_clk  in  1  raw keyboard clock, asynchronous to clk
- ps2_dat  in  1  raw keyboard data, asynchronous to clk
- keycode  out  8  last decoded scan code
- key_make  out  1  1 = press, 0 = release
- key_ext  out  1  1 = E0-prefixed code
- key_valid  out  1  one-cycle pulse when keycode, key_make and key_ext update
- frame_err  out  1  one-cycle pulse on a dropped frame

Function
REQ-004 ps2_clk and ps2_dat SHALL each pass through a 2-flop synchronizer before use.
REQ-005 The filtered ps2_clk SHALL change level only after FILTER_LEN consecutive identical synchronized samples.
REQ-006 A filtered ps2_clk 1->0 transition SHALL be a bit strobe, and the synchronized ps2_dat SHALL be sampled on that cycle.
REQ-007 The frame FSM SHALL have states IDLE, DATA, PARITY and STOP.
- IDLE -> DATA on a strobe with dat=0; a strobe with dat=1 keeps IDLE.
- DATA shifts 8 bits LSB first, then moves to PARITY.
- PARITY captures the parity bit, then moves to STOP.
- STOP returns to IDLE on the next strobe.
REQ-008 A stop bit of 0 SHALL discard the byte and pulse frame_err on the STOP strobe cycle plus 1.
REQ-009 If the FSM is outside IDLE and TIMEOUT_CYC clk cycles pass without a strobe, the FSM SHALL return to IDLE, discard the partial byte, clear the prefix flags and pulse frame_err once.
REQ-010 An accepted byte SHALL reach the byte decoder on the cycle after its STOP strobe.
REQ-011 The byte decoder SHALL act on each accepted byte as follows.
- 0xE0 sets ext_flag.
- 0xF0 sets brk_flag.
- 0xE1 loads skip_cnt=7.
- With skip_cnt>0, a byte only decrements skip_cnt.
- Any other byte emits an event and clears both flags.
REQ-012 An emitted event SHALL drive keycode=byte, key_make=~brk_flag and key_ext=ext_flag, and pulse key_valid for exactly one cycle, 1 cycle after the byte is accepted.
REQ-013 keycode, key_make and key_ext SHALL hold their values between events; prefix bytes and skipped bytes SHALL produce no key_valid.
REQ-014 The prefix flags SHALL be order-independent: E0,F0,xx and F0,E0,xx decode identically.
REQ-015 A timeout or reset occurring at the same time as a strobe SHALL take priority over the strobe.

Reset
REQ-016 Asserting reset=0 SHALL immediately clear the FSM to IDLE, clear the shift register, flags, skip_cnt, filter and timeout counters, and drive keycode=0x00 and key_make=key_ext=key_valid=frame_err=0.
REQ-017 Reset asserted mid-frame SHALL lose the partial byte without pulsing frame_err.

Configuration
REQ-018 With PS2_PARITY_CHECK_EN defined, a frame that fails odd parity (data bits plus parity bit having an even count of ones) SHALL be dropped, pulse frame_err, and not reach the decoder.
REQ-019 Without PS2_PARITY_CHECK_EN, the parity bit SHALL be captured but ignored, and only stop-bit errors and timeouts SHALL drive frame_err.

Structure
REQ-020 A shared package ps2_pkg SHALL hold the frame FSM state enum and the constants PS2_EXT=8'hE0, PS2_BRK=8'hF0 and PS2_PAUSE=8'hE1.
REQ-021 The bit-level receiver (synchronizers, filter, frame FSM, timeout) SHALL be sub-module ps2_rx_frame, with output byte plus a one-cycle byte_valid strobe and frame_err; the prefix decoder SHALL live in ps2_key_decoder.

Verification
REQ-022 Frame 0x1C with good parity -> one key_valid pulse with keycode=0x1C, key_make=1, key_ext=0.
REQ-023 Bytes F0,1C -> one key_valid pulse with keycode=0x1C, key_make=0, key_ext=0; no pulse after F0.
REQ-024 Bytes E0,F0,75 and then F0,E0,75 -> two pulses, each with keycode=0x75, key_make=0, key_ext=1.
REQ-025 Byte 0x1C with a flipped parity bit -> with the macro, frame_err pulses once and there is no key_valid; without it, key_valid pulses with keycode=0x1C.
REQ-026 Stop after 4 data bits for TIMEOUT_CYC+5 cycles, then send 0x29 -> one frame_err pulse, then key_valid with keycode=0x29.
REQ-027 E1 plus 7 bytes followed by 0x1C -> exactly one key_valid pulse with keycode=0x1C; reset=0 mid-frame -> all outputs 0 and no frame_err.
